ts_serial_rx: RTL

TS_SERIAL_RX -- requirements
Module: ts_serial_rx

---
 rtl/ts_pkg.sv | 25 ++
 rtl/ts_uart_rx_byte.sv | 115 +++++++++++
 rtl/ts_serial_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared constants and state encodings for the serial timestamp receiver.
package ts_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    // Bytes that follow the sync byte: channel, four timestamp bytes, checksum.
    localparam int REC_LEN = 6;

    // Each record state is numbered by the position of the byte it expects, so CSUM lands on REC_LEN.
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        CHAN = 3'd1,
        TS3  = 3'd2,
        TS2  = 3'd3,
        TS1  = 3'd4,
        TS0  = 3'd5,
        CSUM = 3'(REC_LEN)
    } rec_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;
endpackage

// File: rtl/ts_uart_rx_byte.sv
// 8N1 byte receiver: synchronizer, mid-bit sampling, stop-bit check.
module ts_uart_rx_byte
    import ts_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            rx_prev_q;
    logic [1:0]      fill_q;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    // Start edges are only trusted once a real sample (not the reset value) has shown the line high.
    always_comb begin
        armed_d = armed_q | ((fill_q == 2'd2) & rx_s);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RX_IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'd0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rxd};
            rx_prev_q <= rx_s;
            fill_q    <= (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (armed_q && rx_prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {rx_s, data_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = valid_q;
        byte_data  = data_q;
        frame_err  = ferr_q;
    end
endmodule

// File: rtl/ts_serial_rx.sv
// Timestamp record receiver: assembles sync/channel/timestamp/checksum records from the byte stream.
module ts_serial_rx
    import ts_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        serialin,
    output logic        rec_valid,
    output logic [1:0]  rec_channel,
    output logic        rec_edge,
    output logic [31:0] rec_timestamp,
    output logic        frame_err,
    output logic        csum_err
);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_ferr;

    rec_state_e  state_q, state_d;
    logic [2:0]  chan_q, chan_d;     // {edge, channel[1:0]}
    logic [31:0] ts_q, ts_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] tmo_q, tmo_d;
    logic        rv_q, rv_d;
    logic        ce_q, ce_d;
    logic [1:0]  och_q, och_d;
    logic        oedge_q, oedge_d;
    logic [31:0] ots_q, ots_d;

    ts_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (serialin),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (rx_ferr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HUNT;
            chan_q  <= 3'd0;
            ts_q    <= 32'd0;
            csum_q  <= 8'd0;
            tmo_q   <= 32'd0;
            rv_q    <= 1'b0;
            ce_q    <= 1'b0;
            och_q   <= 2'd0;
            oedge_q <= 1'b0;
            ots_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            ts_q    <= ts_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            rv_q    <= rv_d;
            ce_q    <= ce_d;
            och_q   <= och_d;
            oedge_q <= oedge_d;
            ots_q   <= ots_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        ts_d    = ts_q;
        csum_d  = csum_q;
        rv_d    = 1'b0;
        ce_d    = 1'b0;
        och_d   = och_q;
        oedge_d = oedge_q;
        ots_d   = ots_q;
        tmo_d   = (state_q == HUNT || byte_valid) ? 32'd0 : tmo_q + 32'd1;
        // Framing errors and inter-byte timeouts silently drop the partial record.
        if (state_q != HUNT && rx_ferr) begin
            state_d = HUNT;
        end else if (state_q != HUNT && tmo_q > TMO_LIMIT) begin
            state_d = HUNT;
        end else if (byte_valid) begin
            case (state_q)
                HUNT: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = CHAN;
                        csum_d  = 8'd0;
                    end
                end
                CHAN: begin
                    chan_d  = {byte_data[7], byte_data[1:0]};
                    csum_d  = csum_q ^ byte_data;
                    state_d = TS3;
                end
                TS3, TS2, TS1, TS0: begin
                    ts_d    = {ts_q[23:0], byte_data};
                    csum_d  = csum_q ^ byte_data;
                    state_d = (state_q == TS0) ? CSUM : rec_state_e'(state_q + 3'd1);
                end
                CSUM: begin
                    state_d = HUNT;
                    if (byte_data == csum_q) begin
                        rv_d    = 1'b1;
                        och_d   = chan_q[1:0];
                        oedge_d = chan_q[2];
                        ots_d   = ts_q;
                    end else begin
                        ce_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        rec_valid     = rv_q;
        csum_err      = ce_q;
        frame_err     = rx_ferr;
        rec_channel   = och_q;
        rec_edge      = oedge_q;
        rec_timestamp = ots_q;
    end
endmodule
